// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter: two-requester valid/ready arbiter sharing one 2:1 mux, bounded bursts, one-entry output register.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise A has fixed priority.
module mux_2_to_1 #(
  parameter int Bit = 16
) (
  input  logic [Bit-1:0] a,
  input  logic [Bit-1:0] b,
  input  logic           sel,
  output logic [Bit-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mux2_bus_arbiter #(
  parameter int Bit       = 16,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_valid,
  input  logic [Bit-1:0] a_data,
  output logic           a_ready,
  input  logic           b_valid,
  input  logic [Bit-1:0] b_data,
  output logic           b_ready,
  output logic           out_valid,
  output logic [Bit-1:0] out_data,
  input  logic           out_ready,
  output logic           sel,
  output logic           busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_sel;
  logic           r_busy;
  logic           r_out_valid;
  logic [Bit-1:0] r_out_data;
  logic [Bit-1:0] w_mux;
  logic           w_grant;
  logic           w_room;
  logic           w_cur_valid;
  logic           w_load;
  logic           w_last;
  logic           w_tie_b;

  mux_2_to_1 #(.Bit(Bit)) u_mux (
    .a  (a_data),
    .b  (b_data),
    .sel(r_sel),
    .y  (w_mux)
  );

  assign w_grant     = r_state != IDLE;
  assign w_room      = !r_out_valid || out_ready;
  assign a_ready     = (r_state == GRANT_A) && w_room;
  assign b_ready     = (r_state == GRANT_B) && w_room;
  assign w_cur_valid = (r_state == GRANT_B) ? b_valid : a_valid;
  assign w_load      = w_grant && w_cur_valid && w_room;
  assign w_last      = w_load && (r_cnt == CW'(MAX_BURST - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  // Tie goes to whoever was not served last (1 = B).
  assign w_tie_b = !r_last_grant;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last_grant <= 1'b1;
    else if (w_grant && w_next == IDLE) r_last_grant <= r_state == GRANT_B;
`else
  assign w_tie_b = 1'b0;
`endif

  assign w_next = !w_grant ? ((a_valid && b_valid) ? (w_tie_b ? GRANT_B : GRANT_A) :
                              a_valid ? GRANT_A : b_valid ? GRANT_B : IDLE) :
                  (!w_cur_valid || w_last) ? IDLE : r_state;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next != IDLE;
      if (!w_grant && w_next != IDLE) begin
        r_sel <= w_next == GRANT_B;
        r_cnt <= '0;
      end else if (w_load) r_cnt <= r_cnt + 1'b1;
      // A load in the same cycle as a drain keeps the stage full with the new word.
      if (w_load) begin
        r_out_data  <= w_mux;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) r_out_valid <= 1'b0;
    end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
  assign busy      = r_busy;
endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// tb_mux2_bus_arbiter: directed and randomized checks of mux2_bus_arbiter against a transaction-level reference model.
module tb_mux2_bus_arbiter;
  localparam int W  = 16;
  localparam int MB = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0;
  logic         b_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_data = '0;
  logic [W-1:0] b_data = '0;
  logic         a_ready;
  logic         b_ready;
  logic         out_valid;
  logic         sel;
  logic         busy;
  logic [W-1:0] out_data;

  mux2_bus_arbiter #(.Bit(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  int           m_own;
  int           m_cnt;
  bit           m_last;
  bit           m_oval;
  bit           m_sel;
  logic [W-1:0] m_odata;
  logic [W-1:0] sb[$];
  logic [W-1:0] pa[$];
  logic [W-1:0] pb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_own = 0; m_cnt = 0; m_last = 1'b1; m_oval = 1'b0; m_sel = 1'b0; m_odata = '0;
    sb.delete();
  endtask

  task automatic cyc(output bit acc_a, output bit acc_b);
    bit room, xv, ld;
    int win;
    logic [W-1:0] xd;
    acc_a = 1'b0; acc_b = 1'b0;
    #2;
    room = !m_oval || out_ready;
    check("a_ready", a_ready, m_own == 1 && room);
    check("b_ready", b_ready, m_own == 2 && room);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("drain_empty", out_valid, 0);
      else check("drain_order", out_data, sb.pop_front());
    end
    if (m_own == 0) begin
      win = (a_valid && b_valid) ? ((RR && !m_last) ? 2 : 1) : a_valid ? 1 : b_valid ? 2 : 0;
      if (m_oval && out_ready) m_oval = 1'b0;
      if (win != 0) begin m_own = win; m_sel = win == 2; m_cnt = 0; end
    end else begin
      xv = (m_own == 1) ? a_valid : b_valid;
      xd = (m_own == 1) ? a_data : b_data;
      ld = xv && room;
      if (ld) begin
        m_odata = xd; m_oval = 1'b1; m_cnt++; sb.push_back(xd);
        acc_a = m_own == 1; acc_b = m_own == 2;
      end else if (m_oval && out_ready) m_oval = 1'b0;
      if (!xv || (ld && m_cnt == MB)) begin m_last = m_own == 2; m_own = 0; end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_oval);
    check("out_data", out_data, m_odata);
    check("sel", sel, m_sel);
    check("busy", busy, m_own != 0);
  endtask

  // Producers hold each word until accepted; gap_pct randomly withdraws valid.
  task automatic run(input int n, input int ordy_pct, input int gap_pct);
    bit acc_a, acc_b;
    for (int i = 0; i < n; i++) begin
      a_valid   = pa.size() > 0 && ($urandom % 100) >= gap_pct;
      b_valid   = pb.size() > 0 && ($urandom % 100) >= gap_pct;
      a_data    = (pa.size() > 0) ? pa[0] : W'($urandom);
      b_data    = (pb.size() > 0) ? pb[0] : W'($urandom);
      out_ready = ($urandom % 100) < ordy_pct;
      cyc(acc_a, acc_b);
      if (acc_a) void'(pa.pop_front());
      if (acc_b) void'(pb.pop_front());
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    rst = 1'b0;

    pa = '{16'h1111, 16'h2222, 16'h3333};
    run(8, 100, 0);

    for (int i = 0; i < 12; i++) begin
      pa.push_back(W'(16'hA000 + i));
      pb.push_back(W'(16'hB000 + i));
    end
    run(14, 100, 0);
    pa.delete(); pb.delete();
    run(4, 100, 0);

    pa = '{16'hAAAA, 16'hBBBB};
    run(3, 0, 0);
    run(1, 100, 0);
    run(2, 0, 0);
    run(3, 100, 0);

    pb = '{16'h0B01, 16'h0B02};
    run(6, 100, 0);

    pb = '{16'h0C01, 16'h0C02, 16'h0C03};
    run(3, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sel", sel, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    pa.delete(); pb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pa = '{16'h0D01, 16'h0D02};
    pb = '{16'h0E01, 16'h0E02};
    run(8, 100, 0);

    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 10)); j++) pa.push_back(W'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 10)); j++) pb.push_back(W'($urandom));
      run(50, $urandom_range(20, 100), $urandom_range(0, 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux2_bus_arbiter.md
# mux2_bus_arbiter

Sequential controller that shares one `mux_2_to_1` datapath between two valid/ready requesters (A on mux input `a`, B on input `b`). It arbitrates, drives the mux select, bounds burst length, and registers the selected word into a one-entry output stage with valid/ready backpressure. It sits between two word producers and a single downstream consumer on the shared bus.

## Interface
- `Bit`, 16, data width; passed to the internal `mux_2_to_1`.
- `MAX_BURST`, 4, maximum transfers per grant; must be ≥1; counter width `$clog2(MAX_BURST+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a word.
- `a_data`  in  Bit  requester A word.
- `a_ready`  out  1  A word accepted this cycle when `a_valid && a_ready`.
- `b_valid`, `b_data`, `b_ready`: same as A, for requester B.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  Bit  output register contents.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `sel`  out  1  registered mux select (0 = A, 1 = B).
- `busy`  out  1  high when the FSM is in a grant state.

## Operation
- Datapath: one `mux_2_to_1 #(Bit)` instance; `a`=`a_data`, `b`=`b_data`, `sel`=`sel`. Its output loads `out_data`.
- FSM states: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - If neither valid: stay.
  - If exactly one valid: go to that grant.
  - If both valid: arbitrate per Configuration.
  - On entry to GRANT_x: `sel` <= x, `burst_cnt` <= 0.
- GRANT_x:
  - `x_ready` = `!out_valid || out_ready`.
  - Other requester's ready = 0.
- Transfer (`x_valid && x_ready`): `out_data` <= mux output, `out_valid` <= 1, `burst_cnt` += 1.
- Exit to IDLE and set `last_grant` <= x when either:
  - `x_valid` is low in a grant cycle; or
  - a transfer makes `burst_cnt` reach `MAX_BURST`.
- Output drain: when `out_valid && out_ready` and no load occurs this cycle, `out_valid` <= 0.
- Simultaneous drain and load: the load wins; `out_valid` stays 1 and `out_data` takes the new word.
- `sel` holds its value in IDLE; it changes only on entry to a grant.
- `out_data` holds its value while `out_valid` is high and no transfer occurs.
- Reset values (asynchronous):
  - state IDLE; `sel` 0; `busy` 0.
  - `out_valid` 0; `out_data` 0; `burst_cnt` 0.
  - `last_grant` = B, so A wins the first tie.
  - `a_ready` and `b_ready` are 0 while in IDLE.
- Reset mid-burst: the in-flight `out_data` is discarded and `out_valid` drops immediately. No transfer is counted for the reset cycle.

## Timing
- Arbitration latency: a requester's valid is sampled in IDLE in cycle n. Its grant state and `sel` are active in n+1. The earliest accept is in n+1.
- Each accepted word appears on `out_data`/`out_valid` one cycle after acceptance.
- Peak throughput is 1 word/cycle within a grant. Each exit to IDLE costs exactly one bubble cycle before the next grant.
- `a_ready`/`b_ready` have a combinational path from `out_ready` and the state register. No other combinational input-to-output paths exist.
- `busy` = (state != IDLE), registered.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined: on a tie in IDLE, the grant goes to the requester not equal to `last_grant` (round robin).
- Undefined: fixed priority, A always wins ties. `last_grant` is not implemented, so B can be starved while A keeps requesting.
- The burst limit applies in both builds.

## Test plan
- Single requester: A sends 0x1111, 0x2222, 0x3333, `out_ready`=1.
  - Out words appear in order, one cycle after each accept.
  - `sel`=0, `b_ready`=0 throughout.
- Tie, round robin (macro defined, `MAX_BURST`=4): both valid continuously, `out_ready`=1.
  - 4 A words, 1 idle cycle, 4 B words, 1 idle cycle, then A again.
  - `sel` sequence is 0, then 1, then 0.
- Tie, fixed priority (macro undefined): same stimulus.
  - Only A words are transferred, in bursts of 4 separated by 1 idle cycle.
  - `b_ready` never asserts.
- Backpressure: A streams 0xAAAA, 0xBBBB with `out_ready`=0.
  - After the first accept, `a_ready`=0; `out_data`=0xAAAA holds with `out_valid`=1.
  - Raising `out_ready` for 1 cycle drains 0xAAAA and loads 0xBBBB in the same edge.
- Early release: B valid for 2 words, then drops.
  - FSM returns to IDLE after the first grant cycle with `b_valid`=0.
  - `burst_cnt` restarts at 0 on the next grant.
- Reset mid-burst: assert `rst` while in GRANT_B with `out_valid`=1.
  - `out_valid`, `sel`, `busy` go to 0 immediately.
  - After release, a tie grants A first.
